rr_arb_mux: RTL and testbench
=============================

// Module: rr_arb_mux
// PURPOSE
//  N-channel, WIDTH-bit round-robin arbitrating multiplexer with one registered output stage.
//  Generalises the 2:1 datapath select into a channel-count-parametrised mux with valid/ready
//  handshakes on every input and on the output.
//  Serves as a shared-resource selector in the CPU datapath (e.g. multiple requesters to one
//  writeback or memory port).
//  Optional forced-select mode reproduces plain fixed-select mux behaviour.
// PARAMETERS
//  NUM_CH  4   number of input channels (>=2)
//  WIDTH   32  data width per channel
//  SEL_W   $clog2(NUM_CH)  width of channel index (derived, do not override)
// PORTS
//  clk_i        in   1             clock; all state updates on rising edge
//  rst_i        in   1             reset, synchronous, active-high
//  valid_i      in   NUM_CH        per-channel request valid
//  data_i       in   NUM_CH*WIDTH  channel k data at [k*WIDTH +: WIDTH]
//  ready_o      out  NUM_CH        per-channel accept; one-hot or zero
//  force_en_i   in   1             1 = fixed-select mode
//  force_sel_i  in   SEL_W         channel used when force_en_i=1
//  valid_o      out  1             output register holds data
//  data_o       out  WIDTH         registered selected data
//  sel_o        out  SEL_W         index of channel that produced data_o
//  ready_i      in   1             downstream accept
// BEHAVIOUR
//  - Reset (rst_i=1 at edge): valid_o=0, data_o=0, sel_o=0, last_grant=NUM_CH-1.
//    Channel 0 therefore has first priority after reset. A pending output is discarded.
//  - load = !valid_o | ready_i (output register empty, or draining this cycle).
//  - Arbitration is combinational and evaluated only when load=1; otherwise ready_o=0.
//  - Round-robin mode (force_en_i=0): grant the first valid channel searching
//    last_grant+1, last_grant+2, ... modulo NUM_CH (wrap-around).
//  - Forced mode (force_en_i=1): grant force_sel_i iff valid_i[force_sel_i]=1.
//    If force_sel_i>=NUM_CH there is no grant.
//  - ready_o[g]=1 only for the granted channel g; a transfer on that input occurs that cycle.
//  - On a grant at the edge: valid_o<=1, data_o<=data_i[g], sel_o<=g, last_grant<=g
//    (last_grant updates in both modes).
//  - On load=1 with no grant: valid_o<=0; data_o and sel_o hold their values.
//  - When valid_o=1 and ready_i=0: data_o, sel_o and valid_o hold stable, and no input
//    is accepted.
//  - Latency is 1 cycle input->output. Throughput is 1 transfer/cycle with ready_i held at 1.
//  - A simultaneous drain and load is a single-cycle swap; there is no bubble.
//  - ready_o may depend on valid_i. valid_o never depends combinationally on ready_i.
//  - Fairness: with all channels continuously valid and ready_i=1, grants cycle
//    0,1,..,NUM_CH-1,0,...
// TESTING
//  1. Reset check: assert rst_i for 2 cycles with all inputs valid
//     -> valid_o=0, data_o=0, sel_o=0, ready_o=0 throughout.
//  2. Round-robin: NUM_CH=4, all valid, data_i[k]=32'hA0+k, ready_i=1
//     -> sel_o sequence 0,1,2,3,0; data_o sequence A0,A1,A2,A3,A0.
//  3. Backpressure: hold ready_i=0 for 3 cycles after a load of ch2
//     -> data_o/sel_o/valid_o stable, ready_o=0; on release ch3 is loaded next cycle.
//  4. Sparse wrap: last_grant=2, only ch1 valid
//     -> grant ch1 (wrap past 3,0), sel_o=1 next cycle.
//  5. Forced mode: force_en_i=1, force_sel_i=2, all valid
//     -> only ch2 is granted repeatedly. Then set force_sel_i=3 with ch3 idle
//     -> valid_o drops to 0.
//  6. Mid-op reset: rst_i during valid_o=1 & ready_i=0
//     -> next cycle valid_o=0; first post-reset grant goes to ch0.

Source files
------------

// File: rtl/rr_arb_mux_if.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb_mux_if
//  Purpose  : Handshake/data bundle for the round-robin arbitrating mux.
//             The slave view belongs to the arbiter and the master view to
//             whatever drives the requesters and the downstream consumer.
//  Revision : 1.0  initial release
// ============================================================================
interface rr_arb_mux_if #(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 32
);
   localparam int SEL_W = $clog2(NUM_CH);

   logic [NUM_CH-1:0]       valid_i;
   logic [NUM_CH*WIDTH-1:0] data_i;
   logic [NUM_CH-1:0]       ready_o;
   logic                    force_en_i;
   logic [SEL_W-1:0]        force_sel_i;
   logic                    valid_o;
   logic [WIDTH-1:0]        data_o;
   logic [SEL_W-1:0]        sel_o;
   logic                    ready_i;

   modport slave (
      input  valid_i, data_i, force_en_i, force_sel_i, ready_i,
      output ready_o, valid_o, data_o, sel_o
   );

   modport master (
      output valid_i, data_i, force_en_i, force_sel_i, ready_i,
      input  ready_o, valid_o, data_o, sel_o
   );
endinterface
`default_nettype wire

// File: rtl/rr_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb_mux
//  Purpose  : NUM_CH-input, WIDTH-bit round-robin arbitrating multiplexer
//             with a single registered output stage and valid/ready on
//             every input and on the output. A forced-select mode turns it
//             into a plain fixed-select mux.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb_mux #(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 32
) (
   input  wire logic   clk_i,
   input  wire logic   rst_i,
   rr_arb_mux_if.slave bus
);
   localparam int SEL_W = $clog2(NUM_CH);
   // Channel 0 must win first after reset, so the pointer starts at the top.
   localparam logic [SEL_W-1:0] c_LAST_RST = SEL_W'(NUM_CH - 1);

   logic              valid_q, valid_d;
   logic [WIDTH-1:0]  data_q,  data_d;
   logic [SEL_W-1:0]  sel_q,   sel_d;
   logic [SEL_W-1:0]  last_q,  last_d;

   logic              w_load;
   logic              w_grant_vld;
   logic [SEL_W-1:0]  w_grant_idx;
   logic [SEL_W-1:0]  w_cand;
   logic [NUM_CH-1:0] w_ready;

   // Arbitration: pick one channel when the output stage can take data.
   always_comb begin
      // Nothing is accepted while reset is held, so ready_o stays low then.
      w_load      = (!valid_q || bus.ready_i) && !rst_i;
      w_grant_vld = 1'b0;
      w_grant_idx = '0;
      w_cand      = '0;
      if (w_load) begin
         if (bus.force_en_i) begin
            // Out-of-range force_sel_i never matches a channel -> no grant.
            for (int k = 0; k < NUM_CH; k++) begin
               if (bus.force_sel_i == SEL_W'(k) && bus.valid_i[k]) begin
                  w_grant_vld = 1'b1;
                  w_grant_idx = SEL_W'(k);
               end
            end
         end else begin
            // Search starts just after the last winner and wraps around.
            for (int off = 1; off <= NUM_CH; off++) begin
               w_cand = SEL_W'((int'(last_q) + off) % NUM_CH);
               if (!w_grant_vld && bus.valid_i[w_cand]) begin
                  w_grant_vld = 1'b1;
                  w_grant_idx = w_cand;
               end
            end
         end
      end
   end

   // One-hot accept towards the granted requester.
   always_comb begin
      w_ready = '0;
      if (w_grant_vld) begin
         w_ready[w_grant_idx] = 1'b1;
      end
   end

   // Next-state of the output register and round-robin pointer.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      sel_d   = sel_q;
      last_d  = last_q;
      if (w_load) begin
         valid_d = w_grant_vld;
         if (w_grant_vld) begin
            data_d = bus.data_i[int'(w_grant_idx)*WIDTH +: WIDTH];
            sel_d  = w_grant_idx;
            last_d = w_grant_idx;
         end
      end
   end

   // State registers with synchronous reset; a pending output is dropped.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         sel_q   <= '0;
         last_q  <= c_LAST_RST;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
      end
   end

   assign bus.ready_o = w_ready;
   assign bus.valid_o = valid_q;
   assign bus.data_o  = data_q;
   assign bus.sel_o   = sel_q;
endmodule
`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_arb_mux
//  Purpose  : Self-checking bench for rr_arb_mux: directed scenarios with
//             literal expectations plus randomized traffic compared every
//             cycle against a behavioural model of the arbitration rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_arb_mux;
   localparam int NUM_CH = 4;
   localparam int WIDTH  = 32;
   localparam int SEL_W  = $clog2(NUM_CH);

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   rr_arb_mux_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();

   rr_arb_mux #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   int               m_sel;
   int               m_last;
   bit               armed = 1'b0;
   logic             m_load;
   int               m_g;
   logic [NUM_CH-1:0] m_rdy;

   // Winner = valid channel at the smallest forward distance after last.
   function automatic int pick(input logic [NUM_CH-1:0] v, input logic fe,
                               input int fs, input int last);
      int best, bestd, d;
      if (fe) return (fs < NUM_CH && v[fs]) ? fs : -1;
      best  = -1;
      bestd = NUM_CH + 1;
      for (int c = 0; c < NUM_CH; c++) begin
         d = (c - last - 1 + 2 * NUM_CH) % NUM_CH;
         if (v[c] && d < bestd) begin
            bestd = d;
            best  = c;
         end
      end
      return best;
   endfunction

   // Compare process: inputs are stable at the falling edge, so check
   // the current outputs, then advance the model over the coming edge.
   always @(negedge clk) begin
      m_load = !m_valid || bus.ready_i;
      m_g    = (rst || !m_load) ? -1 :
               pick(bus.valid_i, bus.force_en_i, int'(bus.force_sel_i), m_last);
      m_rdy  = '0;
      if (m_g >= 0) m_rdy[m_g] = 1'b1;
      if (armed) begin
         check("model valid_o", 64'(bus.valid_o), 64'(m_valid));
         check("model data_o",  64'(bus.data_o),  64'(m_data));
         check("model sel_o",   64'(bus.sel_o),   64'(m_sel));
         check("model ready_o", 64'(bus.ready_o), 64'(m_rdy));
      end
      if (rst) begin
         m_valid = 1'b0;
         m_data  = '0;
         m_sel   = 0;
         m_last  = NUM_CH - 1;
         armed   = 1'b1;
      end else if (armed && m_load) begin
         m_valid = (m_g >= 0);
         if (m_g >= 0) begin
            m_data = bus.data_i[m_g*WIDTH +: WIDTH];
            m_sel  = m_g;
            m_last = m_g;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [NUM_CH-1:0] v, input logic rdy,
                        input logic fe, input logic [SEL_W-1:0] fs);
      bus.valid_i     = v;
      bus.ready_i     = rdy;
      bus.force_en_i  = fe;
      bus.force_sel_i = fs;
      #1;
   endtask

   task automatic expect_out(input string tag, input logic vld,
                             input logic [WIDTH-1:0] d, input int s);
      check({tag, " valid_o"}, 64'(bus.valid_o), 64'(vld));
      check({tag, " data_o"},  64'(bus.data_o),  64'(d));
      check({tag, " sel_o"},   64'(bus.sel_o),   64'(s));
   endtask

   initial begin
      logic [NUM_CH*WIDTH-1:0] d;
      bus.valid_i     = '0;
      bus.data_i      = '0;
      bus.ready_i     = 1'b0;
      bus.force_en_i  = 1'b0;
      bus.force_sel_i = '0;
      for (int k = 0; k < NUM_CH; k++) bus.data_i[k*WIDTH +: WIDTH] = 32'hA0 + k;

      // 1. Reset with all inputs valid
      rst = 1'b1;
      drive(4'b1111, 1'b1, 1'b0, 2'd0);
      cyc();
      expect_out("rst1", 1'b0, 32'h0, 0);
      check("rst1 ready_o", 64'(bus.ready_o), 64'h0);
      cyc();
      expect_out("rst2", 1'b0, 32'h0, 0);
      check("rst2 ready_o", 64'(bus.ready_o), 64'h0);

      // 2. Round-robin fairness
      rst = 1'b0;
      drive(4'b1111, 1'b1, 1'b0, 2'd0);
      check("rr first ready_o", 64'(bus.ready_o), 64'b0001);
      for (int i = 0; i < 5; i++) begin
         cyc();
         expect_out($sformatf("rr%0d", i), 1'b1, 32'hA0 + (i % 4), i % 4);
      end

      // 3. Backpressure after loading ch2 (pointer is at 0)
      drive(4'b0100, 1'b1, 1'b0, 2'd0);
      cyc();
      expect_out("bp load", 1'b1, 32'hA2, 2);
      drive(4'b1111, 1'b0, 1'b0, 2'd0);
      for (int i = 0; i < 3; i++) begin
         check("bp ready_o", 64'(bus.ready_o), 64'h0);
         cyc();
         expect_out("bp hold", 1'b1, 32'hA2, 2);
      end
      drive(4'b1111, 1'b1, 1'b0, 2'd0);
      check("bp release ready_o", 64'(bus.ready_o), 64'b1000);
      cyc();
      expect_out("bp release", 1'b1, 32'hA3, 3);

      // 4. Sparse wrap: last=2, only ch1 valid
      drive(4'b0100, 1'b1, 1'b0, 2'd0);
      cyc();
      drive(4'b0010, 1'b1, 1'b0, 2'd0);
      check("wrap ready_o", 64'(bus.ready_o), 64'b0010);
      cyc();
      expect_out("wrap", 1'b1, 32'hA1, 1);

      // 5. Forced select
      drive(4'b1111, 1'b1, 1'b1, 2'd2);
      for (int i = 0; i < 3; i++) begin
         check("force ready_o", 64'(bus.ready_o), 64'b0100);
         cyc();
         expect_out("force", 1'b1, 32'hA2, 2);
      end
      drive(4'b0111, 1'b1, 1'b1, 2'd3);
      check("force idle ready_o", 64'(bus.ready_o), 64'h0);
      cyc();
      expect_out("force idle", 1'b0, 32'hA2, 2);

      // 6. Reset while output is stalled
      drive(4'b1111, 1'b1, 1'b0, 2'd0);
      cyc();
      expect_out("mid load", 1'b1, 32'hA3, 3);
      drive(4'b1111, 1'b0, 1'b0, 2'd0);
      cyc();
      expect_out("mid stall", 1'b1, 32'hA3, 3);
      rst = 1'b1;
      cyc();
      expect_out("mid rst", 1'b0, 32'h0, 0);
      check("mid rst ready_o", 64'(bus.ready_o), 64'h0);
      rst = 1'b0;
      drive(4'b1111, 1'b1, 1'b0, 2'd0);
      check("post rst ready_o", 64'(bus.ready_o), 64'b0001);
      cyc();
      expect_out("post rst", 1'b1, 32'hA0, 0);

      // 7. Randomized traffic, checked by the model on every cycle
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 59) == 0);
         for (int k = 0; k < NUM_CH; k++) d[k*WIDTH +: WIDTH] = $urandom;
         bus.data_i = d;
         drive(NUM_CH'($urandom), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 4) == 0), SEL_W'($urandom));
         cyc();
      end
      rst = 1'b0;
      cyc();
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
